ps2_kbd_ctrl: RTL and testbench
===============================

# ps2_kbd_ctrl

Scan-code sequencer between the PS/2 receive FIFO and the CPU bus. It drains bytes from the keyboard receiver's ready/data/read-enable interface and parses PS/2 set-2 prefix sequences (E0, F0, E1 pause). It tracks modifier state and pushes decoded key events into a small queue that software reads through a 4-word MMIO window, with an optional level interrupt.

## Interface
- EVT_AW, default 3, event-queue address width (depth = 2^EVT_AW entries)
- clk  in  1  system clock; all state changes on posedge
- rst  in  1  asynchronous, active-high reset
- kbd_data  in  8  byte at the head of the receiver FIFO
- kbd_ready  in  1  receiver FIFO non-empty
- kbd_overflow  in  1  receiver sticky overflow flag
- kbd_read_enable  out  1  pops one receiver byte on this posedge
- mmio_addr  in  2  word select: 0 EVENT, 1 STATUS, 2 CTRL, 3 reserved
- mmio_rd  in  1  read strobe, one cycle
- mmio_wr  in  1  write strobe, one cycle
- mmio_wdata  in  32  write data
- mmio_rdata  out  32  read data, combinational from mmio_addr
- irq  out  1  level interrupt

## Operation
- Consume: kbd_read_enable = enable & kbd_ready & ~evt_full. A byte is consumed exactly when it is high. The parser updates on that posedge.
- Parser FSM states: BASE, E0, F0, E0F0, PAUSE.
  - BASE: E0→E0; F0→F0; E1→PAUSE (skip=7); AA/FA/FE/00/FF are dropped and the FSM stays in BASE; any other byte emits make (ext=0), stays BASE.
  - E0: F0→E0F0; E0→E0; other emits make (ext=1), →BASE.
  - F0: other emits break (ext=0), →BASE. E0 or F0 here is dropped and the FSM stays in F0.
  - E0F0: other emits break (ext=1), →BASE.
  - PAUSE: discard 7 bytes (skip counter decrements per consumed byte). On the 7th byte, emit make code=E1 (ext=0), →BASE.
- Modifiers, updated on the same edge as the emitted event; the event carries the post-update values:
  - lshift = 0x12 non-ext; rshift = 0x59 non-ext; make sets, break clears.
  - ctrl: 0x14 with ext=0 or ext=1; make sets, break clears (left and right are merged).
  - caps: 0x58 make with ext=0 toggles; break has no effect.
- Event word (13 bits): [7:0] code, [8] brk, [9] ext, [10] shift (lshift|rshift), [11] ctrl, [12] caps.
- Queue: synchronous FIFO of 2^EVT_AW entries with EVT_AW+1-bit count, wrapping pointers.
  - Push and pop on the same edge is legal; count is unchanged.
  - When the queue is full, no input bytes are consumed, so back-pressure falls on the receiver FIFO. Events are never dropped here.
- MMIO reads:
  - addr0: {valid[31], 18'b0, event[12:0]}. mmio_rd with valid=1 pops on that posedge. Reading while empty returns 0 and does not pop.
  - addr1: [0] nonempty, [1] full, [2] kbd_overflow, [3+EVT_AW:3] count, rest 0.
  - addr2: [0] enable, [1] irq_en.
  - addr3: 0.
- MMIO writes:
  - addr0: flush queue (count=0, pointers=0).
  - addr2: load enable and irq_en from wdata[1:0]. If enable goes 0, the parser goes to BASE and skip=0 on the same edge; modifiers are kept.
  - addr1 and addr3: ignored.
- irq = irq_en & nonempty (combinational from registers).

## Timing
- Reset (async, immediate): parser BASE, skip 0, modifiers 0, queue empty, enable 1, irq_en 0. Outputs: kbd_read_enable 0, irq 0, mmio_rdata reflects the reset registers.
- Latency: a byte consumed at edge N that completes an event is readable at addr0 from cycle N+1 (valid=1). Minimum is 1 cycle after the final byte.
- Throughput: one input byte per cycle while enabled and not full.
- Simultaneous write flush and push on one edge: the flush wins; the queue ends empty.
- Simultaneous read pop and push: both take effect.
- Simultaneous CTRL write disabling and a consumed byte: kbd_read_enable is already high that cycle, so the byte is popped but discarded, and the parser ends in BASE.

## Test plan
- Bytes 1C, F0 1C → addr0 reads 0x8000001C then 0x8000011C, then 0. STATUS count goes 2→1→0.
- 12, 1C, F0 12, 1C → events 0x41C then 0x01C (shift set, then cleared by the break).
- E0 F0 75 → event 0x375 (ext=1, brk=1). Then 58, F0 58 → two events, both with caps=1 (0x1058, 0x1158).
- E1 14 77 E1 F0 14 F0 77 → exactly one event, 0x0E1. Parser back in BASE; next byte 1C yields 0x01C.
- EVT_AW=3: feed 10 make codes with no reads. Expect count=8, full=1, kbd_read_enable low, receiver still holding 2 bytes. One pop consumes 1 byte next cycle.
- CTRL=0b10 (disabled, irq_en) → irq stays 0, no consumption. CTRL=0b11 with one pending byte → irq high one cycle after the event. Assert rst mid-sequence (after E0) → irq drops immediately, queue empty; next byte 75 yields ext=0.

Source files
------------

// File: rtl/ps2_kbd_ctrl_if.sv
// Keyboard-receiver and MMIO bus signals of the PS/2 scan-code sequencer.
// The master side is the SoC/receiver, the slave side is ps2_kbd_ctrl.
interface ps2_kbd_ctrl_if;
  logic [7:0]  kbd_data;
  logic        kbd_ready;
  logic        kbd_overflow;
  logic        kbd_read_enable;
  logic [1:0]  mmio_addr;
  logic        mmio_rd;
  logic        mmio_wr;
  logic [31:0] mmio_wdata;
  logic [31:0] mmio_rdata;
  logic        irq;

  modport master (
    output kbd_data, kbd_ready, kbd_overflow, mmio_addr, mmio_rd, mmio_wr, mmio_wdata,
    input  kbd_read_enable, mmio_rdata, irq
  );

  modport slave (
    input  kbd_data, kbd_ready, kbd_overflow, mmio_addr, mmio_rd, mmio_wr, mmio_wdata,
    output kbd_read_enable, mmio_rdata, irq
  );
endinterface

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 scan-code sequencer: prefix parser, modifier tracking and an
// MMIO-readable event queue with a level interrupt.
module ps2_kbd_ctrl #(
  parameter int EVT_AW = 3
) (
  input  logic            clk,
  input  logic            rst,
  ps2_kbd_ctrl_if.slave   bus
);
  localparam int DEPTH = 1 << EVT_AW;
  localparam logic [EVT_AW:0]   CNT_ONE  = (EVT_AW+1)'(1);
  localparam logic [EVT_AW:0]   CNT_FULL = (EVT_AW+1)'(DEPTH);
  localparam logic [EVT_AW-1:0] PTR_ONE  = EVT_AW'(1);

  typedef enum logic [2:0] {ST_BASE, ST_E0, ST_F0, ST_E0F0, ST_PAUSE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        skip_q, skip_d;
  logic              lshift_q, lshift_d, rshift_q, rshift_d;
  logic              ctrl_q, ctrl_d, caps_q, caps_d;
  logic              enable_q, enable_d, irq_en_q, irq_en_d;
  logic [EVT_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [EVT_AW:0]   count_q, count_d;
  logic [12:0]       evt_mem [DEPTH];

  logic        nonempty, full, consume, wr_ctrl, parser_kill, flush, pop;
  logic        emit, emit_brk, emit_ext;
  logic [7:0]  emit_code;
  logic [12:0] evt_word;
  logic        unused_wdata;

  assign nonempty    = (count_q != '0);
  assign full        = (count_q == CNT_FULL);
  assign consume     = enable_q & bus.kbd_ready & ~full;
  assign wr_ctrl     = bus.mmio_wr & (bus.mmio_addr == 2'd2);
  assign parser_kill = wr_ctrl & ~bus.mmio_wdata[0];
  assign flush       = bus.mmio_wr & (bus.mmio_addr == 2'd0);
  assign pop         = bus.mmio_rd & (bus.mmio_addr == 2'd0) & nonempty;
  assign unused_wdata = ^bus.mmio_wdata[31:2];

  assign bus.kbd_read_enable = consume;
  assign bus.irq             = irq_en_q & nonempty;

  always_comb begin
    state_d   = state_q;
    skip_d    = skip_q;
    emit      = 1'b0;
    emit_brk  = 1'b0;
    emit_ext  = 1'b0;
    emit_code = bus.kbd_data;
    if (consume) begin
      case (state_q)
        ST_BASE: begin
          case (bus.kbd_data)
            8'hE0: state_d = ST_E0;
            8'hF0: state_d = ST_F0;
            8'hE1: begin state_d = ST_PAUSE; skip_d = 3'd7; end
            8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF: ;
            default: emit = 1'b1;
          endcase
        end
        ST_E0: begin
          case (bus.kbd_data)
            8'hF0: state_d = ST_E0F0;
            8'hE0: ;
            default: begin emit = 1'b1; emit_ext = 1'b1; state_d = ST_BASE; end
          endcase
        end
        ST_F0: begin
          if (bus.kbd_data != 8'hE0 && bus.kbd_data != 8'hF0) begin
            emit = 1'b1; emit_brk = 1'b1; state_d = ST_BASE;
          end
        end
        ST_E0F0: begin
          emit = 1'b1; emit_brk = 1'b1; emit_ext = 1'b1; state_d = ST_BASE;
        end
        ST_PAUSE: begin
          // The pause sequence collapses into a single synthetic E1 make.
          if (skip_q == 3'd1) begin
            emit = 1'b1; emit_code = 8'hE1; skip_d = 3'd0; state_d = ST_BASE;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = ST_BASE;
      endcase
    end
    // A disabling CTRL write discards the byte popped on the same edge.
    if (parser_kill) begin
      state_d = ST_BASE;
      skip_d  = 3'd0;
      emit    = 1'b0;
    end
  end

  always_comb begin
    lshift_d = lshift_q;
    rshift_d = rshift_q;
    ctrl_d   = ctrl_q;
    caps_d   = caps_q;
    if (emit) begin
      if (!emit_ext && emit_code == 8'h12) lshift_d = ~emit_brk;
      if (!emit_ext && emit_code == 8'h59) rshift_d = ~emit_brk;
      if (emit_code == 8'h14)              ctrl_d   = ~emit_brk;
      if (!emit_ext && !emit_brk && emit_code == 8'h58) caps_d = ~caps_q;
    end
    evt_word = {caps_d, ctrl_d, lshift_d | rshift_d, emit_ext, emit_brk, emit_code};
  end

  always_comb begin
    wr_ptr_d = emit ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    count_d  = count_q;
    case ({emit, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: ;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
    enable_d = wr_ctrl ? bus.mmio_wdata[0] : enable_q;
    irq_en_d = wr_ctrl ? bus.mmio_wdata[1] : irq_en_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_BASE;
      skip_q   <= 3'd0;
      lshift_q <= 1'b0;
      rshift_q <= 1'b0;
      ctrl_q   <= 1'b0;
      caps_q   <= 1'b0;
      enable_q <= 1'b1;
      irq_en_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      skip_q   <= skip_d;
      lshift_q <= lshift_d;
      rshift_q <= rshift_d;
      ctrl_q   <= ctrl_d;
      caps_q   <= caps_d;
      enable_q <= enable_d;
      irq_en_q <= irq_en_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; count/pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (emit) evt_mem[wr_ptr_q] <= evt_word;
  end

  always_comb begin
    bus.mmio_rdata = '0;
    case (bus.mmio_addr)
      2'd0: if (nonempty) bus.mmio_rdata = {1'b1, 18'b0, evt_mem[rd_ptr_q]};
      2'd1: begin
        bus.mmio_rdata[0]              = nonempty;
        bus.mmio_rdata[1]              = full;
        bus.mmio_rdata[2]              = bus.kbd_overflow;
        bus.mmio_rdata[3 +: EVT_AW+1]  = count_q;
      end
      2'd2: bus.mmio_rdata[1:0] = {irq_en_q, enable_q};
      default: ;
    endcase
  end
endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: receiver byte model, MMIO reads/writes,
// hand-computed event words checked with immediate assertions.
module tb_ps2_kbd_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] rx_mem [0:255];
  int         rx_wr = 0;
  int         rx_rd = 0;

  ps2_kbd_ctrl_if bus ();

  ps2_kbd_ctrl #(.EVT_AW(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.kbd_data  = rx_mem[rx_rd[7:0]];
  assign bus.kbd_ready = (rx_wr != rx_rd);

  always @(posedge clk) begin
    if (bus.kbd_read_enable && !rst) rx_rd <= rx_rd + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_mem[rx_wr] = b;
    rx_wr++;
  endtask

  task automatic peek(input logic [1:0] a, input string tag, input logic [31:0] exp);
    bus.mmio_addr = a;
    #1;
    chk(tag, bus.mmio_rdata, exp);
  endtask

  task automatic rd_evt(input string tag, input logic [31:0] exp);
    bus.mmio_addr = 2'd0;
    bus.mmio_rd   = 1'b1;
    #1;
    $display("read %s: rdata=%08h", tag, bus.mmio_rdata);
    chk(tag, bus.mmio_rdata, exp);
    @(posedge clk);
    #1;
    bus.mmio_rd = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.mmio_addr  = a;
    bus.mmio_wdata = d;
    bus.mmio_wr    = 1'b1;
    $display("write addr=%0d data=%08h", a, d);
    @(posedge clk);
    #1;
    bus.mmio_wr = 1'b0;
  endtask

  initial begin
    bus.kbd_overflow = 1'b0;
    bus.mmio_addr    = 2'd0;
    bus.mmio_rd      = 1'b0;
    bus.mmio_wr      = 1'b0;
    bus.mmio_wdata   = 32'd0;
    tick(2);
    chk("rst_rd_en", {31'b0, bus.kbd_read_enable}, 32'd0);
    chk("rst_irq", {31'b0, bus.irq}, 32'd0);
    peek(2'd1, "rst_status", 32'h0);
    peek(2'd2, "rst_ctrl", 32'h1);
    peek(2'd3, "rst_rsvd", 32'h0);
    rst = 1'b0;
    tick(1);

    // make / break, count decrement, empty read
    send(8'h1C); send(8'hF0); send(8'h1C);
    tick(5);
    peek(2'd1, "t1_status2", 32'h11);
    rd_evt("t1_make", 32'h8000001C);
    peek(2'd1, "t1_status1", 32'h09);
    rd_evt("t1_break", 32'h8000011C);
    peek(2'd1, "t1_status0", 32'h0);
    rd_evt("t1_empty", 32'h0);
    peek(2'd1, "t1_status_after_empty", 32'h0);

    // shift tracking
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    tick(7);
    rd_evt("t2_lshift_make", 32'h80000412);
    rd_evt("t2_shifted", 32'h8000041C);
    rd_evt("t2_lshift_break", 32'h80000112);
    rd_evt("t2_unshifted", 32'h8000001C);

    // extended break and caps toggling
    send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h58); send(8'hF0); send(8'h58);
    send(8'h58); send(8'hF0); send(8'h58);
    tick(11);
    rd_evt("t3_ext_break", 32'h80000375);
    rd_evt("t3_caps_on", 32'h80001058);
    rd_evt("t3_caps_brk", 32'h80001158);
    rd_evt("t3_caps_off", 32'h80000058);
    rd_evt("t3_caps_brk2", 32'h80000158);

    // pause sequence
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    tick(10);
    peek(2'd1, "t4_status", 32'h09);
    rd_evt("t4_pause", 32'h800000E1);
    send(8'h1C);
    tick(2);
    rd_evt("t4_after", 32'h8000001C);

    // one-cycle latency
    send(8'h2A);
    peek(2'd0, "t5_before", 32'h0);
    tick(1);
    peek(2'd0, "t5_latency", 32'h8000002A);
    rd_evt("t5_pop", 32'h8000002A);

    // overflow passthrough
    bus.kbd_overflow = 1'b1;
    peek(2'd1, "t6_overflow", 32'h04);
    bus.kbd_overflow = 1'b0;

    // full queue back-pressure
    for (int i = 0; i < 10; i++) send(8'h15 + 8'(i));
    tick(12);
    peek(2'd1, "t7_status_full", 32'h43);
    chk("t7_rd_en_full", {31'b0, bus.kbd_read_enable}, 32'd0);
    chk("t7_rx_left", 32'(rx_wr - rx_rd), 32'd2);
    rd_evt("t7_pop", 32'h80000015);
    chk("t7_rd_en_after_pop", {31'b0, bus.kbd_read_enable}, 32'd1);
    tick(1);
    chk("t7_rx_left1", 32'(rx_wr - rx_rd), 32'd1);
    chk("t7_rd_en_refull", {31'b0, bus.kbd_read_enable}, 32'd0);
    peek(2'd1, "t7_status_refull", 32'h43);
    wr(2'd0, 32'd0);
    peek(2'd1, "t7_status_flushed", 32'h0);
    tick(1);
    rd_evt("t7_last", 32'h8000001E);

    // disable on the consuming edge discards the byte and resets the parser
    send(8'hE0);
    tick(2);
    send(8'h75);
    wr(2'd2, 32'd0);
    chk("t8_rx_drained", 32'(rx_wr - rx_rd), 32'd0);
    peek(2'd1, "t8_status", 32'h0);
    wr(2'd2, 32'd1);
    send(8'h75);
    tick(2);
    rd_evt("t8_base_make", 32'h80000075);

    // interrupt gating
    wr(2'd2, 32'd2);
    send(8'h1C);
    tick(3);
    chk("t9_irq_disabled", {31'b0, bus.irq}, 32'd0);
    chk("t9_no_consume", {31'b0, bus.kbd_read_enable}, 32'd0);
    chk("t9_rx_held", 32'(rx_wr - rx_rd), 32'd1);
    peek(2'd2, "t9_ctrl", 32'h2);
    wr(2'd2, 32'd3);
    #1;
    chk("t9_irq_pre", {31'b0, bus.irq}, 32'd0);
    tick(1);
    chk("t9_irq_high", {31'b0, bus.irq}, 32'd1);
    rd_evt("t9_evt", 32'h8000001C);
    chk("t9_irq_low", {31'b0, bus.irq}, 32'd0);

    // asynchronous reset mid-sequence
    send(8'h16); send(8'hE0);
    tick(3);
    chk("t10_irq_pre", {31'b0, bus.irq}, 32'd1);
    peek(2'd1, "t10_status_pre", 32'h09);
    rst = 1'b1;
    #1;
    chk("t10_irq_rst", {31'b0, bus.irq}, 32'd0);
    peek(2'd1, "t10_status_rst", 32'h0);
    peek(2'd2, "t10_ctrl_rst", 32'h1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(8'h75);
    tick(2);
    rd_evt("t10_post_rst", 32'h80000075);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
